// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types for the gcd engine front end
package gcd_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// rtl/gcd_rr_arbiter.sv - combinational round-robin pick starting at ptr
module gcd_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            j = (int'(ptr) + off) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - shares one gcd engine among NREQ requesters round-robin
// Optional WAIT watchdog with error response: define GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [XLEN-1:0]      rsp_data_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic                 rsp_err_o,
    output logic                 eng_ld_o,
    output logic [XLEN-1:0]      eng_a_o,
    output logic [XLEN-1:0]      eng_b_o,
    input  logic                 eng_ready_i,
    input  logic                 eng_valid_i,
    input  logic [XLEN-1:0]      eng_result_i
);

    if (NREQ < 2 || TIMEOUT < 1) begin : g_cfg_check
        $error("gcd_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    arb_state_t      state;
    logic [IDW-1:0]  ptr, ptr_nxt, win_idx, id_q;
    logic [NREQ-1:0] grant;
    logic            win_any;
    logic [XLEN-1:0] win_a, win_b, a_q, b_q, res_q;

    gcd_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign win_a   = req_a_i[int'(win_idx)*XLEN +: XLEN];
    assign win_b   = req_b_i[int'(win_idx)*XLEN +: XLEN];
    assign ptr_nxt = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

    // Gated by reset so a requester holding valid through reset sees no accept.
    assign req_ready_o = (state == ARB_IDLE && resetn_i) ? grant : '0;
    assign eng_ld_o    = (state == ARB_ISSUE) && eng_ready_i;
    assign eng_a_o     = a_q;
    assign eng_b_o     = b_q;
    assign rsp_valid_o = (state == ARB_RESP);
    assign rsp_data_o  = res_q;
    assign rsp_id_o    = id_q;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;
    logic           err_q;
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            id_q  <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            wd    <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win_any) begin
                        a_q  <= win_a;
                        b_q  <= win_b;
                        id_q <= win_idx;
                        ptr  <= ptr_nxt;
`ifdef GCD_ARB_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                        // gcd(x,0)=x and gcd(0,0)=0 both reduce to a|b.
                        if (win_a == '0 || win_b == '0) begin
                            res_q <= win_a | win_b;
                            state <= ARB_RESP;
                        end else begin
                            state <= ARB_ISSUE;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (eng_ready_i) begin
                        state <= ARB_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
                        wd    <= '0;
`endif
                    end
                end
                ARB_WAIT: begin
                    if (eng_valid_i) begin
                        res_q <= eng_result_i;
                        state <= ARB_RESP;
                    end
`ifdef GCD_ARB_TIMEOUT_EN
                    else if (wd == WDW'(TIMEOUT - 1)) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= ARB_RESP;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
`endif
                end
                ARB_RESP: begin
                    if (rsp_ready_i) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - self-checking bench for gcd_arbiter with a behavioural engine
module tb_gcd_arbiter;

    localparam int XLEN    = 32;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic                 clk, resetn;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*XLEN-1:0] req_a, req_b;
    logic                 rsp_valid, rsp_ready, rsp_err;
    logic [XLEN-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 eng_ld, eng_ready, eng_valid;
    logic [XLEN-1:0]      eng_a, eng_b, eng_result;

    int vectors = 0;
    int miscompares = 0;
    int mptr = 0;

    logic            eng_ready_en, eng_stuck, eng_busy, eng_pend, ld_now;
    int              eng_lat, eng_cnt, ld_count;
    logic [XLEN-1:0] opa, opb;

    gcd_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .rsp_err_o    (rsp_err),
        .eng_ld_o     (eng_ld),
        .eng_a_o      (eng_a),
        .eng_b_o      (eng_b),
        .eng_ready_i  (eng_ready),
        .eng_valid_i  (eng_valid),
        .eng_result_i (eng_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [XLEN-1:0] gcd_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [XLEN-1:0] rand_operand(input int g);
        if ($urandom_range(0, 7) == 0) return '0;
        return XLEN'(g * $urandom_range(1, 5000));
    endfunction

    // Engine model: loads on eng_ld, answers with the true gcd after eng_lat idle cycles.
    assign eng_ready = eng_ready_en && !eng_busy;
    initial begin
        eng_valid = 1'b0; eng_result = '0; eng_busy = 1'b0; eng_pend = 1'b0;
        ld_count = 0; eng_cnt = 0; opa = '0; opb = '0;
        forever begin
            @(negedge clk);
            #2;
            ld_now = eng_ld;
            eng_valid = 1'b0;
            if (!resetn) begin
                eng_busy = 1'b0;
                eng_pend = 1'b0;
            end else begin
                if (eng_busy && !eng_stuck) begin
                    if (eng_cnt == 0) begin
                        eng_valid = 1'b1;
                        eng_result = gcd_ref(opa, opb);
                        eng_busy = 1'b0;
                    end else eng_cnt--;
                end
                if (eng_pend) begin
                    eng_pend = 1'b0; eng_busy = 1'b1; eng_cnt = eng_lat;
                end
                if (ld_now) begin
                    eng_pend = 1'b1; opa = eng_a; opb = eng_b; ld_count++;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        req_a[i*XLEN +: XLEN] = a;
        req_b[i*XLEN +: XLEN] = b;
    endtask

    task automatic do_reset;
        @(negedge clk);
        resetn = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        eng_stuck = 1'b0; eng_ready_en = 1'b1; eng_lat = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mptr = 0;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        int c;
        c = 0;
        while (!rsp_valid && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        ok = rsp_valid;
    endtask

    task automatic accept_rsp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; rsp_ready = 1'b0; eng_stuck = 1'b0; eng_ready_en = 1'b1; eng_lat = 0;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd5, 32'd10);
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err, eng_ld} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ready=%b rv=%b id=%0d err=%b ld=%b expected all 0", req_ready, rsp_valid, rsp_id, rsp_err, eng_ld);
        end
        vectors++;
        if ({rsp_data, eng_a, eng_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got data=%0h a=%0h b=%0h expected 0", rsp_data, eng_a, eng_b);
        end
        req_valid = '0;
        @(negedge clk);
        resetn = 1'b1;
        mptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int ld0;
        bit ok;
        @(negedge clk);
        req_valid = 4'b0001;
        set_req(0, 32'd48, 32'd18);
        ld0 = ld_count;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        mptr = 1;
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++;
        if ({eng_ld, eng_a, eng_b} !== {1'b1, 32'd48, 32'd18}) begin
            miscompares++; $display("FAIL single_load: got ld=%b a=%0d b=%0d expected ld=1 a=48 b=18", eng_ld, eng_a, eng_b);
        end
        wait_rsp(50, ok);
        vectors++;
        if (!ok || rsp_data !== gcd_ref(48, 18) || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
            miscompares++; $display("FAIL single_rsp: got v=%b data=%0d id=%0d err=%b expected data=%0d id=0 err=0", ok, rsp_data, rsp_id, rsp_err, gcd_ref(48, 18));
        end
        accept_rsp();
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || ld_count - ld0 !== 1) begin
            miscompares++; $display("FAIL single_after: got rv=%b loads=%0d expected rv=0 loads=1", rsp_valid, ld_count - ld0);
        end
    endtask

    task automatic test_zero;
        int ld0;
        logic [XLEN-1:0] bv;
        ld0 = ld_count;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bv = (t == 0) ? 32'd25 : 32'd0;
            req_valid = 4'b0100;
            set_req(2, 32'd0, bv);
            #1;
            vectors++;
            if (req_ready !== 4'b0100) begin
                miscompares++; $display("FAIL zero_grant: got %b expected 0100", req_ready);
            end
            mptr = 3;
            @(negedge clk);
            req_valid = '0;
            #1;
            vectors++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, gcd_ref(0, bv), 2'd2, 1'b0}) begin
                miscompares++; $display("FAIL zero_rsp: got v=%b data=%0d id=%0d err=%b expected v=1 data=%0d id=2 err=0", rsp_valid, rsp_data, rsp_id, rsp_err, bv);
            end
            accept_rsp();
        end
        vectors++;
        if (ld_count !== ld0) begin
            miscompares++; $display("FAIL zero_noload: got %0d loads expected 0", ld_count - ld0);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [NREQ-1:0] eg;
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd35, 32'd21);
        for (int k = 0; k < 5; k++) begin
            #1;
            eg = '0;
            eg[k % NREQ] = 1'b1;
            vectors++;
            if (req_ready !== eg) begin
                miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, eg);
            end
            wait_rsp(50, ok);
            vectors++;
            if (!ok || rsp_data !== gcd_ref(35, 21) || rsp_id !== IDW'(k % NREQ)) begin
                miscompares++; $display("FAIL rr_rsp%0d: got v=%b data=%0d id=%0d expected data=7 id=%0d", k, ok, rsp_data, rsp_id, k % NREQ);
            end
            accept_rsp();
        end
        req_valid = '0;
        mptr = 1;
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [XLEN-1:0] a, b, exp;
        int g;
        @(negedge clk);
        g = $urandom_range(1, 100);
        a = XLEN'(g * $urandom_range(1, 5000));
        b = XLEN'(g * $urandom_range(1, 5000));
        exp = gcd_ref(a, b);
        req_valid = 4'b0010;
        set_req(1, a, b);
        eng_lat = $urandom_range(0, 3);
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL bp_grant: got %b expected 0010", req_ready);
        end
        mptr = 2;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) if (i != 1) set_req(i, 32'd9, 32'd6);
        req_valid = 4'hF;
        wait_rsp(50, ok);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, exp, 2'd1, 4'b0000}) begin
                miscompares++; $display("FAIL bp_hold%0d: got v=%b data=%0d id=%0d ready=%b expected v=1 data=%0d id=1 ready=0000", c, rsp_valid, rsp_data, rsp_id, req_ready, exp);
            end
        end
        req_valid = '0;
        accept_rsp();
    endtask

    task automatic test_ready_low;
        bit ok;
        logic [XLEN-1:0] a, b;
        @(negedge clk);
        a = XLEN'($urandom_range(1, 100000));
        b = XLEN'($urandom_range(1, 100000));
        eng_ready_en = 1'b0;
        req_valid = 4'b0001;
        set_req(0, a, b);
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL rl_grant: got %b expected 0001", req_ready);
        end
        mptr = 1;
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (eng_ld !== 1'b0) begin
                miscompares++; $display("FAIL rl_noload%0d: got ld=%b expected 0", c, eng_ld);
            end
            @(negedge clk);
        end
        eng_ready_en = 1'b1;
        #1;
        vectors++;
        if ({eng_ld, eng_a, eng_b} !== {1'b1, a, b}) begin
            miscompares++; $display("FAIL rl_load: got ld=%b a=%0d b=%0d expected ld=1 a=%0d b=%0d", eng_ld, eng_a, eng_b, a, b);
        end
        wait_rsp(50, ok);
        vectors++;
        if (!ok || rsp_data !== gcd_ref(a, b) || rsp_id !== 2'd0) begin
            miscompares++; $display("FAIL rl_rsp: got v=%b data=%0d id=%0d expected data=%0d id=0", ok, rsp_data, rsp_id, gcd_ref(a, b));
        end
        accept_rsp();
    endtask

    task automatic test_reset_midop;
        bit ok;
        logic [XLEN-1:0] a1, b1, a3, b3;
        @(negedge clk);
        eng_stuck = 1'b1;
        req_valid = 4'b0010;
        set_req(1, 32'd100, 32'd75);
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL rm_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err, eng_ld, rsp_data, eng_a, eng_b} !== '0) begin
            miscompares++; $display("FAIL rm_zero: got ready=%b rv=%b id=%0d err=%b ld=%b data=%0h a=%0h b=%0h expected all 0", req_ready, rsp_valid, rsp_id, rsp_err, eng_ld, rsp_data, eng_a, eng_b);
        end
        eng_stuck = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mptr = 0;
        a1 = 32'd91; b1 = 32'd39; a3 = 32'd1071; b3 = 32'd462;
        set_req(1, a1, b1);
        set_req(3, a3, b3);
        req_valid = 4'b1010;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL rm_ptr: got %b expected 0010", req_ready);
        end
        mptr = 2;
        @(negedge clk);
        req_valid = 4'b1000;
        wait_rsp(50, ok);
        vectors++;
        if (!ok || rsp_data !== gcd_ref(a1, b1) || rsp_id !== 2'd1) begin
            miscompares++; $display("FAIL rm_rsp1: got v=%b data=%0d id=%0d expected data=%0d id=1", ok, rsp_data, rsp_id, gcd_ref(a1, b1));
        end
        accept_rsp();
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++; $display("FAIL rm_grant3: got %b expected 1000", req_ready);
        end
        mptr = 0;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(50, ok);
        vectors++;
        if (!ok || rsp_data !== gcd_ref(a3, b3) || rsp_id !== 2'd3 || rsp_err !== 1'b0) begin
            miscompares++; $display("FAIL rm_rsp3: got v=%b data=%0d id=%0d err=%b expected data=%0d id=3 err=0", ok, rsp_data, rsp_id, rsp_err, gcd_ref(a3, b3));
        end
        accept_rsp();
    endtask

    task automatic test_timeout;
        int cnt;
        do_reset();
        eng_stuck = 1'b1;
        req_valid = 4'b0001;
        set_req(0, 32'd12, 32'd8);
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL to_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++;
        if (eng_ld !== 1'b1) begin
            miscompares++; $display("FAIL to_load: got ld=%b expected 1", eng_ld);
        end
        cnt = 0;
        while (!rsp_valid && cnt < 60) begin
            @(negedge clk);
            #1;
            cnt++;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        vectors++;
        if (cnt !== TIMEOUT + 1 || {rsp_valid, rsp_err, rsp_data, rsp_id} !== {1'b1, 1'b1, 32'd0, 2'd0}) begin
            miscompares++; $display("FAIL to_rsp: got cycles=%0d v=%b err=%b data=%0d id=%0d expected cycles=%0d v=1 err=1 data=0 id=0", cnt, rsp_valid, rsp_err, rsp_data, rsp_id, TIMEOUT + 1);
        end
        accept_rsp();
`else
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL to_none: got rsp_valid=%b after %0d cycles expected 0", rsp_valid, cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_random;
        bit ok;
        logic [NREQ-1:0] pv, eg;
        logic [XLEN-1:0] pa [NREQ];
        logic [XLEN-1:0] pb [NREQ];
        logic [XLEN-1:0] ea, eb;
        int w, ld0, g;
        pv = '0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1 || (pv == '0 && i == NREQ - 1))) begin
                    g = $urandom_range(1, 100);
                    pa[i] = rand_operand(g);
                    pb[i] = rand_operand(g);
                    pv[i] = 1'b1;
                    set_req(i, pa[i], pb[i]);
                end
            end
            req_valid = pv;
            eng_lat = $urandom_range(0, 3);
            ld0 = ld_count;
            #1;
            w = rr_pick(pv, mptr);
            eg = '0;
            eg[w] = 1'b1;
            vectors++;
            if (req_ready !== eg) begin
                miscompares++; $display("FAIL rnd_grant%0d: got %b expected %b", n, req_ready, eg);
            end
            ea = pa[w];
            eb = pb[w];
            pv[w] = 1'b0;
            mptr = (w + 1) % NREQ;
            @(negedge clk);
            req_valid = pv;
            wait_rsp(100, ok);
            vectors++;
            if (!ok || {rsp_data, rsp_id, rsp_err} !== {gcd_ref(ea, eb), IDW'(w), 1'b0}) begin
                miscompares++; $display("FAIL rnd_rsp%0d: got v=%b data=%0d id=%0d err=%b expected data=%0d id=%0d err=0", n, ok, rsp_data, rsp_id, rsp_err, gcd_ref(ea, eb), w);
            end
            vectors++;
            if (ld_count - ld0 !== ((ea == 0 || eb == 0) ? 0 : 1)) begin
                miscompares++; $display("FAIL rnd_loads%0d: got %0d loads for a=%0d b=%0d", n, ld_count - ld0, ea, eb);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept_rsp();
        end
        req_valid = '0;
    endtask

    initial begin
        resetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        eng_ready_en = 1'b1; eng_stuck = 1'b0; eng_lat = 0;
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_backpressure();
        test_ready_low();
        test_reset_midop();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_watchdog: time limit reached after %0d vectors", vectors);
        $fatal(1, "simulation time limit");
    end

endmodule
